uart_rx_fifo: RTL

Receive-side buffer that sits directly downstream of the UART receiver. It drains each received byte from the receiver's `rdy`/`dout`/`rdy_clr` handshake into a first-word-fall-through FIFO. Bytes are presented to the host logic on a valid/ready stream, so a slow consumer no longer loses characters at line rate. The block runs entirely in the `clk_50m` domain.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_fifo_mem.sv | 34 +++
 rtl/uart_rx_fifo.sv | 130 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared widths and capture-FSM encoding for the UART RX path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

   localparam int UART_DATA_W     = 8;
   localparam int UART_DROP_CNT_W = 8;

   typedef logic [1:0] cap_state_t;

   localparam cap_state_t CAP_IDLE = 2'd0;
   localparam cap_state_t CAP_ACK  = 2'd1;
   localparam cap_state_t CAP_WAIT = 2'd2;

endpackage

`default_nettype wire

// File: rtl/uart_fifo_mem.sv
// ============================================================================
//  Module      : uart_fifo_mem
//  Description : 2**DEPTH_LOG2 x 8 storage, one write port, async read port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                   clk_50m,
   input  logic                   wr_en,
   input  logic [DEPTH_LOG2-1:0]  wr_addr,
   input  logic [UART_DATA_W-1:0] wr_data,
   input  logic [DEPTH_LOG2-1:0]  rd_addr,
   output logic [UART_DATA_W-1:0] rd_data
);

   logic [UART_DATA_W-1:0] mem [0:(1 << DEPTH_LOG2)-1];

   // Storage is deliberately not reset; validity is tracked by the pointers.
   always_ff @(posedge clk_50m) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Drains UART receiver bytes into a FWFT FIFO with a valid/ready
//                output. Define UART_RX_FIFO_OVERRUN_EN for drop reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                       clk_50m,
   input  logic                       rst_n,
   input  logic                       rx_rdy,
   input  logic [UART_DATA_W-1:0]     rx_data,
   output logic                       rx_rdy_clr,
   output logic [UART_DATA_W-1:0]     m_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [DEPTH_LOG2:0]        count
`ifdef UART_RX_FIFO_OVERRUN_EN
   ,
   output logic                       overrun,
   output logic [UART_DROP_CNT_W-1:0] drop_cnt,
   input  logic                       ovr_clr
`endif
);

   cap_state_t               state;
   cap_state_t               state_nxt;
   logic [DEPTH_LOG2-1:0]    wr_ptr;
   logic [DEPTH_LOG2-1:0]    rd_ptr;
   logic [UART_DATA_W-1:0]   head;
   logic                     pop;
   logic                     space;
   logic                     wr_en;

   // Occupancy never exceeds DEPTH, so the MSB alone marks full.
   assign m_valid = (count != '0);
   assign pop     = m_valid && m_ready;
   assign space   = !count[DEPTH_LOG2] || pop;
   assign m_data  = m_valid ? head : '0;

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state <= CAP_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         CAP_IDLE: if (rx_rdy) state_nxt = CAP_ACK;
         CAP_ACK:  state_nxt = CAP_WAIT;
         CAP_WAIT: if (!rx_rdy) state_nxt = CAP_IDLE;
         default:  state_nxt = CAP_IDLE;
      endcase
   end

   always_comb begin
      wr_en = 1'b0;
      if ((state == CAP_IDLE) && rx_rdy) begin
         wr_en = space;
      end
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         rx_rdy_clr <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
      end else begin
         rx_rdy_clr <= (state_nxt == CAP_ACK);
         if (wr_en) begin
            wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         end
         case ({wr_en, pop})
            2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
            2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef UART_RX_FIFO_OVERRUN_EN
   logic drop;

   assign drop = (state == CAP_IDLE) && rx_rdy && !space;

   // A drop in the same cycle as a clear leaves a count of exactly one.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         overrun  <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overrun <= 1'b1;
         if (ovr_clr) begin
            drop_cnt <= UART_DROP_CNT_W'(1);
         end else if (!(&drop_cnt)) begin
            drop_cnt <= drop_cnt + UART_DROP_CNT_W'(1);
         end
      end else if (ovr_clr) begin
         overrun  <= 1'b0;
         drop_cnt <= '0;
      end
   end
`endif

   uart_fifo_mem #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_mem (
      .clk_50m (clk_50m),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (rx_data),
      .rd_addr (rd_ptr),
      .rd_data (head)
   );

endmodule

`default_nettype wire
